// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, 9600-baud
// divider constants for a 50 MHz clock, and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int BPS_PARA      = 5208;
    localparam int BPS_PARA_2    = 2604;
    localparam int CLK_PER_BIT   = BPS_PARA + 1;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_frame.sv
// UART frame serialiser driven by an external bit-tick generator (bps_start / clk_bps).
// Optional even parity bit after the payload when UART_TX_PARITY_EN is defined.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 bps_start,
    input  logic                 clk_bps,
    output logic                 txd
);

    localparam logic [3:0] LP_DATA_BITS = 4'(DATA_BITS);
    localparam logic [1:0] LP_STOP_LAST = 2'(STOP_BITS - 1);

    tx_state_t              r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [3:0]             r_bit_cnt;
    logic [1:0]             r_stop_cnt;
    logic                   r_txd;
    logic                   r_bps_start;
    logic                   r_busy;

    tx_state_t              w_state_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [3:0]             w_bit_cnt_nxt;
    logic [1:0]             w_stop_cnt_nxt;
    logic                   w_txd_nxt;
    logic                   w_bps_start_nxt;
    logic                   w_busy_nxt;
    logic                   w_accept;

`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
    logic                   w_parity_nxt;
`endif

    assign w_accept  = tx_valid && (r_state == ST_IDLE);
    assign tx_ready  = (r_state == ST_IDLE);
    assign tx_busy   = r_busy;
    assign bps_start = r_bps_start;
    assign txd       = r_txd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= '0;
            r_txd       <= 1'b1;
            r_bps_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_stop_cnt  <= w_stop_cnt_nxt;
            r_txd       <= w_txd_nxt;
            r_bps_start <= w_bps_start_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_stop_cnt_nxt  = r_stop_cnt;
        w_txd_nxt       = r_txd;
        w_bps_start_nxt = r_bps_start;
        w_busy_nxt      = r_busy;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt    = r_parity;
`endif

        case (r_state)
            ST_IDLE: begin
                // Ticks seen here are stale or spurious; only an accept moves us on.
                if (w_accept) begin
                    w_shift_nxt     = tx_data;
                    w_bit_cnt_nxt   = '0;
                    w_stop_cnt_nxt  = '0;
                    w_bps_start_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = ST_ARM;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt    = ^tx_data;
`endif
                end
            end

            ST_ARM: begin
                // The generator's first tick lands mid-period; starting here aligns
                // every following bit edge to a tick.
                if (clk_bps) begin
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (clk_bps) begin
                    w_txd_nxt     = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = 4'd1;
                    w_state_nxt   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (clk_bps) begin
                    if (r_bit_cnt < LP_DATA_BITS) begin
                        w_txd_nxt     = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        w_txd_nxt   = r_parity;
                        w_state_nxt = ST_PARITY;
`else
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (clk_bps) begin
                    w_txd_nxt   = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (clk_bps) begin
                    if (r_stop_cnt == LP_STOP_LAST) begin
                        w_stop_cnt_nxt  = '0;
                        w_bps_start_nxt = 1'b0;
                        w_busy_nxt      = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt  = r_stop_cnt + 2'd1;
                    end
                end
            end

            default: begin
                w_txd_nxt       = 1'b1;
                w_bps_start_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame with a scaled-down bit-tick generator; the reference model
// treats a frame as a bit vector whose bits are delimited by consecutive ticks.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int DB = DEF_DATA_BITS;
    localparam int SB = DEF_STOP_BITS;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB       = 1 + DB + P + SB;
    localparam int PER      = 16;
    localparam int HALF     = PER / 2;
    localparam int FALL_LAT = HALF + 2;
    localparam int NFRAMES  = 60;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          spur     = 1'b0;
    logic          tx_ready;
    logic          tx_busy;
    logic          bps_start;
    logic          clk_bps;
    logic          txd;

    int n_chk  = 0;
    int n_pass = 0;
    logic q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .bps_start (bps_start),
        .clk_bps   (clk_bps),
        .txd       (txd)
    );

    // Bit-tick generator: counter held at 0 while bps_start is low, tick at the half period.
    int   g_cnt  = 0;
    logic g_tick = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            g_cnt  <= 0;
            g_tick <= 1'b0;
        end else if (!bps_start) begin
            g_cnt  <= 0;
            g_tick <= 1'b0;
        end else begin
            g_cnt  <= (g_cnt == PER - 1) ? 0 : g_cnt + 1;
            g_tick <= (g_cnt == HALF);
        end
    end
    assign clk_bps = g_tick | spur;

    // Reference model: line idles high; after the k-th tick of a frame the line carries
    // frame bit k-1; tick NB+1 ends the frame.
    function automatic logic [NB-1:0] frame_of(input logic [DB-1:0] d);
        logic [NB-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1+i] = d[i];
        if (P == 1) f[1+DB] = ^d;
        return f;
    endfunction

    logic          m_active = 1'b0;
    int            m_idx    = 0;
    logic          m_txd    = 1'b1;
    logic [NB-1:0] m_bits   = '1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_idx    <= 0;
            m_txd    <= 1'b1;
            m_bits   <= '1;
        end else if (!m_active) begin
            if (tx_valid) begin
                m_active <= 1'b1;
                m_idx    <= 0;
                m_bits   <= frame_of(tx_data);
            end
        end else if (clk_bps) begin
            if (m_idx == NB) begin
                m_active <= 1'b0;
                m_txd    <= 1'b1;
            end else begin
                m_txd <= m_bits[m_idx];
                m_idx <= m_idx + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        chk("txd",       32'(txd),       32'(m_txd));
        chk("tx_ready",  32'(tx_ready),  32'(!m_active));
        chk("tx_busy",   32'(tx_busy),   32'(m_active));
        chk("bps_start", 32'(bps_start), 32'(m_active));
    endtask

    task automatic pulse_reset();
        #6 rst = 1'b1;
        tx_valid = 1'b0;
        spur     = 1'b0;
        repeat (3) tick();
        #6 rst = 1'b0;
        tick();
    endtask

    task automatic send_decode(input logic [DB-1:0] d, output int fall_n, output int len_m,
                               output logic [15:0] smp);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        fall_n = 0;
        while (txd !== 1'b0 && fall_n < 4 * PER) begin
            tick();
            fall_n++;
        end
        smp   = '1;
        len_m = 0;
        while (tx_ready !== 1'b1 && len_m < (NB + 2) * PER) begin
            tick();
            len_m++;
            if ((len_m % PER) == PER / 2 && (len_m / PER) < 16) smp[len_m / PER] = txd;
        end
    endtask

    task automatic decode(input int from, output logic [DB-1:0] d, output int nxt);
        int i;
        int s;
        i = from;
        while (i < q.size() && q[i] !== 1'b0) i++;
        for (int k = 0; k < DB; k++) begin
            s = i + (1 + k) * PER + PER / 2;
            if (s < q.size()) d[k] = q[s];
            else d[k] = 1'bx;
        end
        nxt = i + NB * PER;
    endtask

    initial begin
        logic [7:0]    lit;
        logic [DB-1:0] d1;
        logic [DB-1:0] d2;
        logic [15:0]   smp;
        int            fall_n;
        int            len_m;
        int            n_lo;
        int            n_rdy;
        int            nxt;
        int            c;
        int            rst_at;
        int            gap;
        logic          b2b;
        logic          do_rst;

        $display("hardware bit period %0d clk (divider %0d, half %0d); bench generator uses %0d/%0d",
                 CLK_PER_BIT, BPS_PARA, BPS_PARA_2, PER, HALF);

        tick();
        tick();
        #6 rst = 1'b0;
        tick();

        // Idle with stray ticks: line must stay quiet.
        for (int i = 0; i < 200; i++) begin
            spur = ($urandom_range(0, 9) == 0);
            tick();
        end
        spur = 1'b0;

        // 0x55: pins latency, bit timing and frame length.
        lit = 8'h55;
        send_decode(lit[DB-1:0], fall_n, len_m, smp);
        chk("x55_fall_latency", 32'(fall_n), 32'(FALL_LAT));
        chk("x55_frame_len",    32'(len_m),  32'(NB * PER));
        chk("x55_start_bit",    32'(smp[0]), 32'(0));
        chk("x55_data",         32'(smp[DB:1]), 32'(lit[DB-1:0]));
        chk("x55_stop_bit",     32'(smp[NB-1]), 32'(1));
        repeat (3) tick();

        // 0xA3 then 0x0F with tx_valid held; tx_data changes while the first frame is busy.
        lit      = 8'hA3;
        tx_data  = lit[DB-1:0];
        tx_valid = 1'b1;
        tick();
        lit     = 8'h0F;
        tx_data = lit[DB-1:0];
        q.delete();
        n_lo  = 0;
        n_rdy = 0;
        for (int i = 0; i < (2 * NB + 2) * PER + 4 * HALF; i++) begin
            tick();
            if (n_rdy == 1) tx_valid = 1'b0;
            if (tx_ready === 1'b1) n_rdy++;
            if (n_rdy >= 2) break;
            if (bps_start === 1'b0) n_lo++;
            q.push_back(txd);
        end
        tx_valid = 1'b0;
        decode(0, d1, nxt);
        decode(nxt, d2, nxt);
        lit = 8'hA3;
        chk("b2b_first",   32'(d1), 32'(lit[DB-1:0]));
        lit = 8'h0F;
        chk("b2b_second",  32'(d2), 32'(lit[DB-1:0]));
        chk("b2b_bps_gap", 32'(n_lo), 32'(1));
        chk("b2b_ready_pulses", 32'(n_rdy), 32'(2));
        repeat (3) tick();

        // Reset in the middle of data bit 4 of 0xFF, then a clean 0x00.
        lit      = 8'hFF;
        tx_data  = lit[DB-1:0];
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        c = 0;
        while (txd !== 1'b0 && c < 4 * PER) begin
            tick();
            c++;
        end
        repeat (5 * PER + PER / 2) tick();
        #6 rst = 1'b1;
        tick();
        chk("rst_txd_high",  32'(txd),       32'(1));
        chk("rst_bps_low",   32'(bps_start), 32'(0));
        chk("rst_ready",     32'(tx_ready),  32'(1));
        chk("rst_busy",      32'(tx_busy),   32'(0));
        tick();
        tick();
        #6 rst = 1'b0;
        tick();
        lit = 8'h00;
        send_decode(lit[DB-1:0], fall_n, len_m, smp);
        chk("post_rst_fall",  32'(fall_n), 32'(FALL_LAT));
        chk("post_rst_data",  32'(smp[DB:1]), 32'(lit[DB-1:0]));
        chk("post_rst_len",   32'(len_m), 32'(NB * PER));
        tick();

        // Randomised traffic: data, back-to-back, gaps with stray ticks, mid-frame resets.
        for (int f = 0; f < NFRAMES; f++) begin
            spur     = 1'b0;
            tx_data  = DB'($urandom);
            tx_valid = 1'b1;
            tick();
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) tx_valid = 1'b0;
            do_rst = ($urandom_range(0, 7) == 0);
            rst_at = $urandom_range(1, NB * PER);
            c = 0;
            while (m_active && c < (NB + 2) * PER + 4 * HALF) begin
                tick();
                c++;
                if (b2b) tx_data = DB'($urandom);
                if (do_rst && c == rst_at) pulse_reset();
            end
            if (!b2b) begin
                tx_valid = 1'b0;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    spur = $urandom_range(0, 1) == 1;
                    tick();
                end
                spur = 1'b0;
            end
        end
        tx_valid = 1'b0;
        c = 0;
        while (m_active && c < (NB + 2) * PER + 4 * HALF) begin
            tick();
            c++;
        end
        chk("final_idle", 32'(tx_ready), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
